regfile_writeback: RTL and testbench

Write-side front end for the 32-entry integer register file. Accepts completed results from two producers, the ALU path and the load path, and buffers load data in a small FIFO. Each load value is sign- or zero-extended by access width. The block arbitrates both producers onto the register file's single write port (WE, Rw, Din), issuing at most one registered write per cycle.

---
 rtl/regfile_writeback.sv | 185 ++++++++++++++++++
 tb/tb_regfile_writeback.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-side front end for the 32-entry integer register file. Results from
//   the ALU path (one-entry holding stage) and the load path (DEPTH-entry FIFO,
//   data extended by access width on push) are arbitrated round-robin onto the
//   register file's single registered write port.
//
// Ports
//   CLK, RST_N              clock, asynchronous active-low reset
//   ALU_VALID/RD/DATA/READY ALU result handshake
//   LD_VALID/RD/FUNCT3/DATA/READY
//                           load result handshake (FUNCT3 = RV64 load code)
//   WE, Rw, Din             registered register-file write port
//
// Optional feature (macro WB_BYPASS_EN)
//   QA, QB                  read selects to compare against the pending write
//   HIT_A/B, FWD_A/B        forwarding of the write committed at the next edge
module regfile_writeback #(
  parameter int SIZE  = 64,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            ALU_VALID,
  input  logic [4:0]      ALU_RD,
  input  logic [SIZE-1:0] ALU_DATA,
  output logic            ALU_READY,
  input  logic            LD_VALID,
  input  logic [4:0]      LD_RD,
  input  logic [2:0]      LD_FUNCT3,
  input  logic [SIZE-1:0] LD_DATA,
  output logic            LD_READY,
  output logic            WE,
  output logic [4:0]      Rw,
  output logic [SIZE-1:0] Din
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]      QA,
  input  logic [4:0]      QB,
  output logic            HIT_A,
  output logic            HIT_B,
  output logic [SIZE-1:0] FWD_A,
  output logic [SIZE-1:0] FWD_B
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic            alu_full_q, alu_full_d;
  logic [4:0]      alu_rd_q, alu_rd_d;
  logic [SIZE-1:0] alu_data_q, alu_data_d;

  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [SIZE-1:0] fifo_data_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // 1 = the most recent grant went to the load path
  logic            last_ld_q, last_ld_d;

  logic            we_q, we_d;
  logic [4:0]      rw_q, rw_d;
  logic [SIZE-1:0] din_q, din_d;

  logic            alu_push, ld_push;
  logic            grant_alu, grant_ld;

  function automatic logic [SIZE-1:0] extend(input logic [2:0] f3, input logic [SIZE-1:0] d);
    case (f3)
      3'b000:  extend = {{(SIZE-8){d[7]}},   d[7:0]};
      3'b001:  extend = {{(SIZE-16){d[15]}}, d[15:0]};
      3'b010:  extend = {{(SIZE-32){d[31]}}, d[31:0]};
      3'b011:  extend = d;
      3'b100:  extend = {{(SIZE-8){1'b0}},   d[7:0]};
      3'b101:  extend = {{(SIZE-16){1'b0}},  d[15:0]};
      3'b110:  extend = {{(SIZE-32){1'b0}},  d[31:0]};
      default: extend = '0;
    endcase
  endfunction

  // Readiness on the load side looks only at the registered count, so a full
  // FIFO refuses a push even in a cycle where it is also being drained.
  assign LD_READY = (count_q < CW'(DEPTH));
  assign ld_push  = LD_VALID && LD_READY;

  always_comb begin
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (alu_full_q && (count_q != '0)) begin
      if (last_ld_q) grant_alu = 1'b1;
      else           grant_ld  = 1'b1;
    end else begin
      grant_alu = alu_full_q;
      grant_ld  = (count_q != '0);
    end
  end

  // Granting the held ALU entry frees the stage in the same cycle.
  assign ALU_READY = !alu_full_q || grant_alu;
  assign alu_push  = ALU_VALID && ALU_READY;

  always_comb begin
    alu_full_d = alu_full_q;
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(ld_push) - CW'(grant_ld);
    last_ld_d  = last_ld_q;
    we_d       = 1'b0;
    rw_d       = rw_q;
    din_d      = din_q;

    if (alu_push) begin
      alu_full_d = 1'b1;
      alu_rd_d   = ALU_RD;
      alu_data_d = ALU_DATA;
    end else if (grant_alu) begin
      alu_full_d = 1'b0;
    end

    if (ld_push)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (grant_ld) rd_ptr_d = rd_ptr_q + AW'(1);

    // x0 destinations still consume a grant; only the enable is suppressed.
    if (grant_alu) begin
      we_d      = (alu_rd_q != 5'd0);
      rw_d      = alu_rd_q;
      din_d     = alu_data_q;
      last_ld_d = 1'b0;
    end else if (grant_ld) begin
      we_d      = (fifo_rd_q[rd_ptr_q] != 5'd0);
      rw_d      = fifo_rd_q[rd_ptr_q];
      din_d     = fifo_data_q[rd_ptr_q];
      last_ld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_full_q <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_ld_q  <= 1'b0;
      we_q       <= 1'b0;
      rw_q       <= '0;
      din_q      <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_ld_q  <= last_ld_d;
      we_q       <= we_d;
      rw_q       <= rw_d;
      din_q      <= din_d;
    end
  end

  // Storage needs no reset: entries are only read when count_q says valid.
  always_ff @(posedge CLK) begin
    if (ld_push) begin
      fifo_rd_q[wr_ptr_q]   <= LD_RD;
      fifo_data_q[wr_ptr_q] <= extend(LD_FUNCT3, LD_DATA);
    end
  end

  assign WE  = we_q;
  assign Rw  = rw_q;
  assign Din = din_q;

`ifdef WB_BYPASS_EN
  assign HIT_A = we_q && (rw_q == QA) && (QA != 5'd0);
  assign HIT_B = we_q && (rw_q == QB) && (QB != 5'd0);
  assign FWD_A = HIT_A ? din_q : '0;
  assign FWD_B = HIT_B ? din_q : '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  localparam int SIZE  = 64;
  localparam int DEPTH = 4;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            ALU_VALID = 1'b0;
  logic [4:0]      ALU_RD = '0;
  logic [SIZE-1:0] ALU_DATA = '0;
  logic            ALU_READY;
  logic            LD_VALID = 1'b0;
  logic [4:0]      LD_RD = '0;
  logic [2:0]      LD_FUNCT3 = '0;
  logic [SIZE-1:0] LD_DATA = '0;
  logic            LD_READY;
  logic            WE;
  logic [4:0]      Rw;
  logic [SIZE-1:0] Din;
`ifdef WB_BYPASS_EN
  logic [4:0]      QA = '0;
  logic [4:0]      QB = '0;
  logic            HIT_A, HIT_B;
  logic [SIZE-1:0] FWD_A, FWD_B;
`endif

  regfile_writeback #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .LD_VALID(LD_VALID), .LD_RD(LD_RD), .LD_FUNCT3(LD_FUNCT3), .LD_DATA(LD_DATA),
    .LD_READY(LD_READY),
    .WE(WE), .Rw(Rw), .Din(Din)
`ifdef WB_BYPASS_EN
    , .QA(QA), .QB(QB), .HIT_A(HIT_A), .HIT_B(HIT_B), .FWD_A(FWD_A), .FWD_B(FWD_B)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t alu_q[$];
  ent_t ld_q[$];
  int   wlog[$];
  int   wcyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic last_alu_acc, last_ld_acc;
  int ld_acc_n, ld_wr_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ext_model(input logic [2:0] f, input logic [63:0] d);
    case (f)
      3'd0:    return {{56{d[7]}}, d[7:0]};
      3'd1:    return {{48{d[15]}}, d[15:0]};
      3'd2:    return {{32{d[31]}}, d[31:0]};
      3'd3:    return d;
      3'd4:    return {56'd0, d[7:0]};
      3'd5:    return {48'd0, d[15:0]};
      3'd6:    return {32'd0, d[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  // One clock: observe the write port and handshakes at the falling edge,
  // then advance past the rising edge.
  task automatic step();
    ent_t e;
    @(negedge CLK);
    if (RST_N && WE) begin
      if (ld_q.size() > 0 && ld_q[0].rd == Rw) begin
        e = ld_q.pop_front();
        ld_wr_n++;
        chk("sb_ld_din", Din, e.data);
      end else if (alu_q.size() > 0) begin
        e = alu_q.pop_front();
        chk("sb_alu_rw", 64'(Rw), 64'(e.rd));
        chk("sb_alu_din", Din, e.data);
      end else begin
        chk("spurious_we", 64'(WE), 64'd0);
      end
      wlog.push_back(int'(Rw));
      wcyc.push_back(cyc);
    end
    last_alu_acc = ALU_VALID && ALU_READY;
    last_ld_acc  = LD_VALID && LD_READY;
    if (last_alu_acc && ALU_RD != 5'd0) alu_q.push_back({ALU_RD, ALU_DATA});
    if (last_ld_acc && LD_RD != 5'd0) ld_q.push_back({LD_RD, ext_model(LD_FUNCT3, LD_DATA)});
    if (last_ld_acc) ld_acc_n++;
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #3;
    chk("rst_we", 64'(WE), 64'd0);
    chk("rst_rw", 64'(Rw), 64'd0);
    chk("rst_din", Din, 64'd0);
    chk("rst_alu_ready", 64'(ALU_READY), 64'd1);
    chk("rst_ld_ready", 64'(LD_READY), 64'd1);
    alu_q.delete();
    ld_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] data;
    logic [63:0] exp;
  } ext_case_t;

  ext_case_t ext_tab[$];

  initial begin
    int alu_sent, ld_sent;
    logic saw_full;
    int occ;

    ALU_VALID = 1'b0;
    LD_VALID  = 1'b0;
    #2;
    do_reset();

    // Single ALU result: accept edge, grant edge, then WE for one cycle
    ALU_VALID = 1'b1; ALU_RD = 5'd5; ALU_DATA = 64'h1234;
    step();
    chk("lat_after_accept_we", 64'(WE), 64'd0);
    ALU_VALID = 1'b0;
    step();
    chk("lat_we", 64'(WE), 64'd1);
    chk("lat_rw", 64'(Rw), 64'd5);
    chk("lat_din", Din, 64'h1234);
    step();
    chk("lat_we_after", 64'(WE), 64'd0);

    // Load extension by funct3
    ext_tab.push_back('{3'b000, 64'h8080, 64'hFFFF_FFFF_FFFF_FF80});
    ext_tab.push_back('{3'b100, 64'h8080, 64'h0000_0000_0000_0080});
    ext_tab.push_back('{3'b001, 64'h8080, 64'hFFFF_FFFF_FFFF_8080});
    ext_tab.push_back('{3'b011, 64'h8080, 64'h0000_0000_0000_8080});
    ext_tab.push_back('{3'b101, 64'hFFFF_8080, 64'h0000_0000_0000_8080});
    ext_tab.push_back('{3'b010, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_8000_0001});
    ext_tab.push_back('{3'b110, 64'h1234_5678_8000_0001, 64'h0000_0000_8000_0001});
    ext_tab.push_back('{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    foreach (ext_tab[i]) begin
      LD_VALID = 1'b1; LD_RD = 5'd9; LD_FUNCT3 = ext_tab[i].f3; LD_DATA = ext_tab[i].data;
      step();
      LD_VALID = 1'b0;
      step();
      chk($sformatf("ext_we_f3_%0d", ext_tab[i].f3), 64'(WE), 64'd1);
      chk($sformatf("ext_din_f3_%0d", ext_tab[i].f3), Din, ext_tab[i].exp);
      step();
    end

    // Conflict from reset: load wins first, then alternation
    do_reset();
    wlog.delete(); wcyc.delete();
    ALU_VALID = 1'b1; ALU_RD = 5'd1; ALU_DATA = 64'h111;
    LD_VALID = 1'b1; LD_RD = 5'd2; LD_FUNCT3 = 3'b011; LD_DATA = 64'h222;
    step();
    ALU_VALID = 1'b0;
    LD_RD = 5'd3; LD_DATA = 64'h333;
    step();
    LD_VALID = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("conf_nwrites", 64'(wlog.size()), 64'd3);
    if (wlog.size() == 3) begin
      chk("conf_order0", 64'(wlog[0]), 64'd2);
      chk("conf_order1", 64'(wlog[1]), 64'd1);
      chk("conf_order2", 64'(wlog[2]), 64'd3);
      chk("conf_consecutive", 64'(wcyc[2] - wcyc[0]), 64'd2);
    end

    // Sustained contention until the load FIFO fills, then drain
    do_reset();
    alu_sent = 0; ld_sent = 0; saw_full = 1'b0;
    ld_acc_n = 0; ld_wr_n = 0;
    for (int i = 0; i < 80 && !(alu_sent == 10 && ld_sent == 10); i++) begin
      ALU_VALID = (alu_sent < 10);
      ALU_RD    = 5'(10 + alu_sent);
      ALU_DATA  = 64'hA000 + 64'(alu_sent);
      LD_VALID  = (ld_sent < 10);
      LD_RD     = 5'(20 + ld_sent);
      LD_FUNCT3 = 3'b010;
      LD_DATA   = {32'h5555_5555, 32'h8000_0000 + 32'(ld_sent)};
      if (!LD_READY && !saw_full) begin
        saw_full = 1'b1;
        occ = ld_acc_n - ld_wr_n - ((WE && Rw >= 5'd20 && Rw < 5'd30) ? 1 : 0);
        chk("full_occupancy", 64'(occ), 64'(DEPTH));
      end
      step();
      if (last_alu_acc) alu_sent++;
      if (last_ld_acc) ld_sent++;
    end
    ALU_VALID = 1'b0; LD_VALID = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("full_seen", 64'(saw_full), 64'd1);
    chk("full_all_sent", 64'(alu_sent + ld_sent), 64'd20);
    chk("drain_alu_empty", 64'(alu_q.size()), 64'd0);
    chk("drain_ld_empty", 64'(ld_q.size()), 64'd0);

    // x0 destination: granted, no write enable, values still carried
    ALU_VALID = 1'b1; ALU_RD = 5'd0; ALU_DATA = 64'h5A5A;
    step();
    ALU_VALID = 1'b0;
    step();
    chk("x0_we", 64'(WE), 64'd0);
    chk("x0_rw", 64'(Rw), 64'd0);
    chk("x0_din", Din, 64'h5A5A);
    chk("x0_alu_ready", 64'(ALU_READY), 64'd1);
    step();
    chk("x0_we_after", 64'(WE), 64'd0);

    // Reset with loads buffered behind a busy ALU path
    ALU_VALID = 1'b1; ALU_RD = 5'd4; ALU_DATA = 64'h44;
    LD_VALID = 1'b1; LD_FUNCT3 = 3'b011;
    for (int i = 0; i < 4; i++) begin
      LD_RD = 5'(11 + i); LD_DATA = 64'(i);
      step();
    end
    ALU_VALID = 1'b0; LD_VALID = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_reset_we_%0d", i), 64'(WE), 64'd0);
    end
    chk("post_reset_ld_ready", 64'(LD_READY), 64'd1);

`ifdef WB_BYPASS_EN
    ALU_VALID = 1'b1; ALU_RD = 5'd7; ALU_DATA = 64'hAB;
    step();
    ALU_VALID = 1'b0;
    step();
    QA = 5'd7; QB = 5'd3;
    #1;
    chk("byp_hit_a", 64'(HIT_A), 64'd1);
    chk("byp_fwd_a", FWD_A, 64'hAB);
    chk("byp_hit_b", 64'(HIT_B), 64'd0);
    QA = 5'd0;
    #1;
    chk("byp_hit_a_x0", 64'(HIT_A), 64'd0);
    chk("byp_fwd_a_x0", FWD_A, 64'd0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
